// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares the data memory's single port between the CPU (port 0)
// and the loader (port 1). Each granted request is sequenced IDLE -> ACCESS -> RESP.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_port;
  logic                  r_we;
  logic                  r_err_pending;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_rvalid0;
  logic                  r_rvalid1;

  logic                  w_idle;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_sel_we;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_addr_err;

  // r_last_grant = 1 means port 1 was granted last, so port 0 wins the next contention.
  assign w_idle = (r_state == S_IDLE) && rst_n;
  assign w_gnt0 = w_idle && req0 && (!req1 || r_last_grant);
  assign w_gnt1 = w_idle && req1 && (!req0 || !r_last_grant);

  assign w_sel_we    = w_gnt1 ? we1    : we0;
  assign w_sel_addr  = w_gnt1 ? addr1  : addr0;
  assign w_sel_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_addr_err  = (w_sel_addr[DATA_WIDTH-1:ADDR_WIDTH] != '0) || (w_sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_port        <= 1'b0;
      r_we          <= 1'b0;
      r_err_pending <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_port        <= w_gnt1;
            r_last_grant  <= w_gnt1;
            r_we          <= w_sel_we;
            r_addr        <= w_sel_addr;
            r_wdata       <= w_sel_wdata;
            r_err_pending <= w_addr_err;
            r_state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rdata   <= (r_we || r_err_pending) ? '0 : mem_rd;
          r_err     <= r_err_pending;
          r_rvalid0 <= !r_port;
          r_rvalid1 <= r_port;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_rvalid0 <= 1'b0;
          r_rvalid1 <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // rst_n gates the write strobe directly so an access aborted by reset never commits.
  assign mem_we  = (r_state == S_ACCESS) && r_we && !r_err_pending && rst_n;
  assign mem_a   = r_addr;
  assign mem_wd  = r_wdata;
  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
  assign err     = r_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed little-endian data memory model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory model: preload port for the bench, otherwise written by the DUT.
  logic [7:0]  mem [0:131071];
  logic        pl_we = 1'b0;
  logic [16:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;
  logic [14:0] rd_idx;

  always @(posedge clk) begin
    if (pl_we) begin
      for (int b = 0; b < 4; b++) mem[{pl_a[16:2], 2'b00} + 17'(b)] <= pl_d[8*b +: 8];
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) mem[{mem_a[16:2], 2'b00} + 17'(b)] <= mem_wd[8*b +: 8];
    end
  end

  assign rd_idx = mem_a[16:2];
  always_comb mem_rd = {mem[{rd_idx, 2'd3}], mem[{rd_idx, 2'd2}], mem[{rd_idx, 2'd1}], mem[{rd_idx, 2'd0}]};

  function automatic logic [31:0] mem_word(input logic [16:0] a);
    return {mem[{a[16:2], 2'd3}], mem[{a[16:2], 2'd2}], mem[{a[16:2], 2'd1}], mem[{a[16:2], 2'd0}]};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] d);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_we = 1'b0;
  endtask

  // One full transaction: grant (N), ACCESS (N+1), RESP (N+2); returns at N+3 just after the edge.
  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    logic got;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_value("grant", {31'd0, got}, 32'd1);
    if (!got) begin
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      return;
    end
    check_value("gnt_other", {31'd0, (port == 0) ? gnt1 : gnt0}, 32'd0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check_value("access_mem_we", {31'd0, mem_we}, {31'd0, we & ~exp_err});
    check_value("access_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check_value("access_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    if (we && !exp_err) begin
      check_value("access_mem_a", mem_a, addr);
      check_value("access_mem_wd", mem_wd, wdata);
    end
    tick();
    @(negedge clk);
    check_value("resp_rvalid", {30'd0, rvalid1, rvalid0}, (port == 0) ? 32'd1 : 32'd2);
    check_value("resp_rdata", rdata, exp_rdata);
    check_value("resp_err", {31'd0, err}, {31'd0, exp_err});
    check_value("resp_mem_we", {31'd0, mem_we}, 32'd0);
    $display("txn port=%0d we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d",
             port, we, addr, wdata, rdata, err);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1;
    tick();
    preload(17'h00000, 32'h00000000);
    preload(17'h00004, 32'h55667788);
    preload(17'h00010, 32'hDEADBEEF);
    preload(17'h00020, 32'h00000000);
    preload(17'h00040, 32'hAABBCCDD);
    preload(17'h1FFFC, 32'h00000000);

    // Reset state
    @(negedge clk);
    check_value("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check_value("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check_value("rst_rdata", rdata, 32'd0);
    check_value("rst_err", {31'd0, err}, 32'd0);
    check_value("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_value("rst_mem_a", mem_a, 32'd0);
    check_value("rst_mem_wd", mem_wd, 32'd0);

    // Contention held from reset: grants alternate 0,1,0,1 every 3 cycles
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h10;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] exp_g;
      logic [31:0] exp_v;
      exp_g = 0;
      exp_v = 0;
      if (k % 3 == 0) exp_g = ((k / 3) % 2 == 0) ? 32'd1 : 32'd2;
      if (k % 3 == 2) exp_v = ((k / 3) % 2 == 0) ? 32'd1 : 32'd2;
      @(negedge clk);
      check_value($sformatf("cont_gnt_c%0d", k), {30'd0, gnt1, gnt0}, exp_g);
      check_value($sformatf("cont_rvalid_c%0d", k), {30'd0, rvalid1, rvalid0}, exp_v);
      if (exp_v != 0) begin
        check_value($sformatf("cont_rdata_c%0d", k), rdata, 32'hDEADBEEF);
        $display("txn contention port=%0d rdata=0x%08h err=%0d", (exp_v == 2) ? 1 : 0, rdata, err);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Single read on port 0
    do_access(0, 1'b0, 32'h00000010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Write then read on port 1 at the top word of the region
    do_access(1, 1'b1, 32'h0001FFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    do_access(1, 1'b0, 32'h0001FFFC, 32'h0, 32'hCAFEF00D, 1'b0);
    check_value("byte_1fffc", {24'd0, mem[17'h1FFFC]}, 32'h0D);
    check_value("byte_1fffd", {24'd0, mem[17'h1FFFD]}, 32'hF0);
    check_value("byte_1fffe", {24'd0, mem[17'h1FFFE]}, 32'hFE);
    check_value("byte_1ffff", {24'd0, mem[17'h1FFFF]}, 32'hCA);

    // Errors: out-of-range write, misaligned read
    do_access(0, 1'b1, 32'h00020000, 32'h11111111, 32'h0, 1'b1);
    check_value("err_mem_word0", mem_word(17'h0), 32'h00000000);
    do_access(1, 1'b0, 32'h00000006, 32'h0, 32'h0, 1'b1);

    // Reset asserted during the ACCESS cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
    @(negedge clk);
    check_value("rstmid_grant", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_value("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_value("rstmid_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check_value("rstmid_rdata", rdata, 32'd0);
    check_value("rstmid_err", {31'd0, err}, 32'd0);
    check_value("rstmid_mem_a", mem_a, 32'd0);
    check_value("rstmid_mem_wd", mem_wd, 32'd0);
    check_value("rstmid_mem_we2", {31'd0, mem_we}, 32'd0);
    check_value("rstmid_word20", mem_word(17'h20), 32'd0);
    $display("txn reset-abort port=0 addr=0x00000020 rvalid0=%0d", rvalid0);
    tick();
    do_access(0, 1'b0, 32'h00000020, 32'h0, 32'h0, 1'b0);

    // Hold after response
    do_access(0, 1'b0, 32'h00000040, 32'h0, 32'hAABBCCDD, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value($sformatf("hold_rdata_c%0d", k), rdata, 32'hAABBCCDD);
      check_value($sformatf("hold_quiet_c%0d", k), {27'd0, gnt0, gnt1, rvalid0, rvalid1, mem_we}, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
